// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF challenge sequencer:
// FSM state encoding, LFSR tap mask and default seed.
package puf_pkg;

    localparam int CHAL_W = 8;

    localparam logic [CHAL_W-1:0] LFSR_SEED_DEFAULT = 8'h01;
    // Feedback taps on challenge bits 7, 3, 2 and 1.
    localparam logic [CHAL_W-1:0] LFSR_TAPS = 8'b1000_1110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/puf_lfsr_step.sv
// Combinational one-step advance of the 8-bit challenge LFSR
// (shift left, feedback = parity of the tapped bits).
module puf_lfsr_step
    import puf_pkg::*;
(
    input  logic [CHAL_W-1:0] cur,
    output logic [CHAL_W-1:0] stepped
);

    logic feedback;

    assign feedback = ^(cur & LFSR_TAPS);
    assign stepped  = {cur[CHAL_W-2:0], feedback};

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives the PUF with an LFSR challenge stream and packs one response bit per
// challenge into a word. Optional 2-of-3 vote on the sample: PUF_MAJORITY_VOTE_EN.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int CHAL_W        = 8,
    parameter int RESP_BITS     = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [CHAL_W-1:0]    seed,
    output logic                 busy,
    output logic [CHAL_W-1:0]    challenge,
    output logic                 challenge_valid,
    input  logic                 puf_response,
    output logic [RESP_BITS-1:0] resp_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [1:0]           dbg_state
);

    localparam int CNT_W = $clog2(RESP_BITS + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(RESP_BITS - 1);

    state_t                 state;
    state_t                 next_state;
    logic [SET_W-1:0]       settle_cnt;
    logic [CNT_W-1:0]       bit_cnt;
    logic [RESP_BITS-1:0]   resp_shift;
    logic [CHAL_W-1:0]      challenge_stepped;
    logic [CHAL_W-1:0]      seed_safe;
    logic                   sample_bit;

    puf_lfsr_step u_lfsr_step (
        .cur     (challenge),
        .stepped (challenge_stepped)
    );

    // An all-zero LFSR never leaves zero, so substitute the default seed.
    assign seed_safe = (seed == '0) ? CHAL_W'(LFSR_SEED_DEFAULT) : seed;

`ifdef PUF_MAJORITY_VOTE_EN
    logic vote_early;
    logic vote_late;

    assign sample_bit = (vote_early & vote_late) | (vote_early & puf_response)
                      | (vote_late & puf_response);
`else
    assign sample_bit = puf_response;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == '0) next_state = ST_SAMPLE;
            ST_SAMPLE: next_state = (bit_cnt == LAST_BIT) ? ST_DONE : ST_SETTLE;
            ST_DONE:   if (resp_ready) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            challenge  <= '0;
            resp_shift <= '0;
            bit_cnt    <= '0;
            settle_cnt <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
            vote_early <= 1'b0;
            vote_late  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        challenge  <= seed_safe;
                        resp_shift <= '0;
                        bit_cnt    <= '0;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
                    if (settle_cnt == SET_W'(1)) vote_early <= puf_response;
                    if (settle_cnt == '0)        vote_late  <= puf_response;
`endif
                end
                ST_SAMPLE: begin
                    resp_shift <= {resp_shift[RESP_BITS-2:0], sample_bit};
                    challenge  <= challenge_stepped;
                    bit_cnt    <= bit_cnt + 1'b1;
                    settle_cnt <= SETTLE_LOAD;
                end
                default: ;
            endcase
        end
    end

    // Valid/ready: resp_valid holds with resp_data stable until the cycle
    // resp_ready is seen high; the word is consumed on that edge.
    assign busy            = (state != ST_IDLE);
    assign challenge_valid = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign resp_valid      = (state == ST_DONE);
    assign resp_data       = resp_shift;
    assign dbg_state       = state;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench for puf_challenge_sequencer: independent LFSR/PUF model
// feeds an expected-word queue; timing, handshake and reset are checked inline.
module tb_puf_challenge_sequencer;

    localparam int RESP_BITS = 16;
    localparam int SETTLE    = 4;
    localparam int RUN_CYC   = RESP_BITS * (SETTLE + 1);

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  seed;
    logic        busy;
    logic [7:0]  challenge;
    logic        challenge_valid;
    logic        puf_response;
    logic [15:0] resp_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  dbg_state;

    logic [15:0] exp_q[$];
    int          n_vec;
    int          n_err;

    puf_challenge_sequencer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .seed            (seed),
        .busy            (busy),
        .challenge       (challenge),
        .challenge_valid (challenge_valid),
        .puf_response    (puf_response),
        .resp_data       (resp_data),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .dbg_state       (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr(input logic [7:0] c);
        return {c[6:0], c[1] ^ c[2] ^ c[3] ^ c[7]};
    endfunction

    // mode 0: PUF stuck at 0; mode 1: parity of challenge;
    // mode 2: 0 with one-cycle glitch at window position 2,3,4 in rotation.
    task automatic run_word(input logic [7:0] sd, input int mode, input int hold);
        logic [7:0]  mc;
        logic [7:0]  first;
        logic [15:0] w;
        logic        b;
        int          pos;
        int          bi;
        first = (sd == 8'h00) ? 8'h01 : sd;
        mc = first;
        w = '0;
        for (int i = 0; i < RESP_BITS; i++) begin
`ifdef PUF_MAJORITY_VOTE_EN
            b = (mode == 1) ? ^mc : 1'b0;
`else
            b = (mode == 1) ? ^mc : ((mode == 2) ? ((i % 3) == 2) : 1'b0);
`endif
            w = {w[14:0], b};
            mc = lfsr(mc);
        end
        exp_q.push_back(w);

        mc = first;
        @(negedge clk);
        seed  = sd;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL start_busy got %b want 1", busy); end
        n_vec++; if (challenge_valid !== 1'b1) begin n_err++; $display("FAIL start_cvalid got %b want 1", challenge_valid); end
        n_vec++; if (challenge !== first) begin n_err++; $display("FAIL start_challenge got %h want %h", challenge, first); end
        n_vec++; if (resp_data !== 16'h0000) begin n_err++; $display("FAIL start_clear got %h want 0000", resp_data); end

        for (int k = 0; k < RUN_CYC; k++) begin
            @(negedge clk);
            pos = k % (SETTLE + 1);
            bi  = k / (SETTLE + 1);
            if (mode == 1)      puf_response = ^challenge;
            else if (mode == 2) puf_response = (pos == (bi % 3) + 2);
            else                puf_response = 1'b0;
            if (pos == SETTLE) begin
                n_vec++; if (challenge !== mc || challenge_valid !== 1'b1 || resp_valid !== 1'b0) begin
                    n_err++; $display("FAIL sample_bit%0d got chal=%h cv=%b rv=%b want chal=%h cv=1 rv=0",
                                      bi, challenge, challenge_valid, resp_valid, mc);
                end
                mc = lfsr(mc);
            end
        end
        @(posedge clk);
        #1;
        puf_response = 1'b0;
        n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL valid_latency got %b want 1", resp_valid); end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++; $display("FAIL scoreboard_empty got %h want queued word", resp_data);
        end else begin
            w = exp_q.pop_front();
            if (resp_data !== w) begin n_err++; $display("FAIL resp_word got %h want %h", resp_data, w); end
        end

        for (int j = 0; j < hold; j++) begin
            @(negedge clk);
            start = j[0];
            n_vec++; if (resp_valid !== 1'b1 || busy !== 1'b1 || resp_data !== w) begin
                n_err++; $display("FAIL done_hold%0d got rv=%b busy=%b data=%h want rv=1 busy=1 data=%h",
                                  j, resp_valid, busy, resp_data, w);
            end
        end
        @(negedge clk);
        start      = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (resp_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
            n_err++; $display("FAIL handshake_idle got rv=%b busy=%b st=%0d want rv=0 busy=0 st=0",
                              resp_valid, busy, dbg_state);
        end
        n_vec++; if (resp_data !== w) begin n_err++; $display("FAIL idle_hold got %h want %h", resp_data, w); end
        @(negedge clk);
        start      = 1'b0;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; seed = 8'h00; puf_response = 1'b0; resp_ready = 1'b0;
        #1;
        n_vec++; if ({busy, challenge, challenge_valid, resp_data, resp_valid, dbg_state} !== '0) begin
            n_err++; $display("FAIL reset_values got busy=%b chal=%h cv=%b data=%h rv=%b st=%0d want all 0",
                              busy, challenge, challenge_valid, resp_data, resp_valid, dbg_state);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset got %b want 0", busy); end
    endtask

    task automatic test_lfsr_step();    run_word(8'h01, 0, 0); endtask
    task automatic test_zero_seed();    run_word(8'h00, 0, 0); endtask
    task automatic test_parity();       run_word(8'h01, 1, 0); endtask
    task automatic test_backpressure(); run_word(8'hA5, 1, 10); endtask
    task automatic test_majority();     run_word(8'h5A, 2, 0); endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        seed  = 8'h3C;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7 * (SETTLE + 1) + 2) begin
            @(negedge clk);
            puf_response = ^challenge;
        end
        reset_n = 1'b0;
        #1;
        n_vec++; if ({busy, challenge, challenge_valid, resp_data, resp_valid} !== '0) begin
            n_err++; $display("FAIL midrun_reset got busy=%b chal=%h cv=%b data=%h rv=%b want all 0",
                              busy, challenge, challenge_valid, resp_data, resp_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        puf_response = 1'b0;
        run_word(8'h3C, 1, 0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            run_word(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_lfsr_step();
        test_zero_seed();
        test_parity();
        test_backpressure();
        test_majority();
        test_reset_mid_run();
        test_back_to_back();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL leftover_words got %0d want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
